// File: rtl/ysyx_23060208_rd_arbiter.sv
// Two-master (IFU, LSU) to one-slave AXI-lite read-channel arbiter.
// One outstanding read at a time, fixed priority LSU over IFU.
//
// Handshake rule: a beat transfers on a rising edge where valid and ready are
// both high. Valid never waits on ready. Once asserted, valid and its payload
// stay stable until the transfer. Ready may depend combinationally on valid.
module ysyx_23060208_rd_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // IFU read master
    input  logic [ADDR_WIDTH-1:0] ifu_araddr,
    input  logic                  ifu_arvalid,
    output logic                  ifu_arready,
    output logic [DATA_WIDTH-1:0] ifu_rdata,
    output logic [1:0]            ifu_rresp,
    output logic                  ifu_rvalid,
    input  logic                  ifu_rready,
    // LSU read master
    input  logic [ADDR_WIDTH-1:0] lsu_araddr,
    input  logic                  lsu_arvalid,
    output logic                  lsu_arready,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic [1:0]            lsu_rresp,
    output logic                  lsu_rvalid,
    input  logic                  lsu_rready,
    // Shared memory read port
    output logic [ADDR_WIDTH-1:0] mem_araddr,
    output logic                  mem_arvalid,
    input  logic                  mem_arready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic [1:0]            mem_rresp,
    input  logic                  mem_rvalid,
    output logic                  mem_rready,
    // FSM state for observation: 0=IDLE, 1=ADDR, 2=DATA
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  gnt_q,   gnt_d;   // 0 = IFU, 1 = LSU
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;

    assign mem_araddr  = addr_q;
    assign dbg_state_o = state_q;

    // State, grant and latched address registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state logic, arbitration and response routing
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        addr_d      = addr_q;
        ifu_arready = 1'b0;
        lsu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = 2'b00;
        lsu_rvalid  = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = 2'b00;
        mem_arvalid = 1'b0;
        mem_rready  = 1'b0;

        case (state_q)
            IDLE: begin
                // No request is accepted while reset is held, so nothing is
                // lost when the registers are cleared on this edge.
                if (!rst) begin
                    if (lsu_arvalid) begin
                        lsu_arready = 1'b1;
                        addr_d      = lsu_araddr;
                        gnt_d       = 1'b1;
                        state_d     = ADDR;
                    end else if (ifu_arvalid) begin
                        ifu_arready = 1'b1;
                        addr_d      = ifu_araddr;
                        gnt_d       = 1'b0;
                        state_d     = ADDR;
                    end
                end
            end
            ADDR: begin
                // mem_arvalid is a pure function of state, so it has no
                // combinational path from any mem_* input.
                mem_arvalid = 1'b1;
                if (mem_arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (gnt_q) begin
                    mem_rready = lsu_rready;
                    lsu_rvalid = mem_rvalid;
                    lsu_rdata  = mem_rdata;
                    lsu_rresp  = mem_rresp;
                end else begin
                    mem_rready = ifu_rready;
                    ifu_rvalid = mem_rvalid;
                    ifu_rdata  = mem_rdata;
                    ifu_rresp  = mem_rresp;
                end
                if (mem_rvalid && mem_rready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060208_rd_arbiter.sv
// Directed bench for the two-master read arbiter.
module tb_ysyx_23060208_rd_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] ifu_araddr  = '0;
    logic          ifu_arvalid = 1'b0;
    logic          ifu_arready;
    logic [DW-1:0] ifu_rdata;
    logic [1:0]    ifu_rresp;
    logic          ifu_rvalid;
    logic          ifu_rready  = 1'b0;
    logic [AW-1:0] lsu_araddr  = '0;
    logic          lsu_arvalid = 1'b0;
    logic          lsu_arready;
    logic [DW-1:0] lsu_rdata;
    logic [1:0]    lsu_rresp;
    logic          lsu_rvalid;
    logic          lsu_rready  = 1'b0;
    logic [AW-1:0] mem_araddr;
    logic          mem_arvalid;
    logic          mem_arready = 1'b0;
    logic [DW-1:0] mem_rdata   = '0;
    logic [1:0]    mem_rresp   = 2'b00;
    logic          mem_rvalid  = 1'b0;
    logic          mem_rready;
    logic [1:0]    dbg_state;

    ysyx_23060208_rd_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid),
        .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid),
        .lsu_rready(lsu_rready),
        .mem_araddr(mem_araddr), .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
        .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rvalid(mem_rvalid),
        .mem_rready(mem_rready),
        .dbg_state_o(dbg_state)
    );

    // Memory address handshakes seen on the bus
    int hs_cnt = 0;
    always @(posedge clk) begin
        if (!rst && mem_arvalid && mem_arready) hs_cnt <= hs_cnt + 1;
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one cycle: inputs change 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #1;
    endtask

    int hs_start;
    logic [AW-1:0] held_addr;

    initial begin
        // ---------- reset ----------
        tick(); tick();
        settle();
        chk("rst_state",   dbg_state,   S_IDLE);
        chk("rst_arvalid", mem_arvalid, 1'b0);
        chk("rst_araddr",  mem_araddr,  32'h0);
        chk("rst_rready",  mem_rready,  1'b0);
        chk("rst_ifu_rv",  ifu_rvalid,  1'b0);
        chk("rst_lsu_rv",  lsu_rvalid,  1'b0);
        rst = 1'b0;

        // ---------- test 1: single IFU read ----------
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0000; ifu_rready = 1'b1;
        settle();
        chk("t1_ifu_arready", ifu_arready, 1'b1);
        chk("t1_lsu_arready", lsu_arready, 1'b0);
        chk("t1_arvalid_idle", mem_arvalid, 1'b0);
        tick();
        ifu_arvalid = 1'b0; mem_arready = 1'b1;
        settle();
        chk("t1_arvalid", mem_arvalid, 1'b1);
        chk("t1_araddr",  mem_araddr,  32'h8000_0000);
        chk("t1_ifu_arready_addr", ifu_arready, 1'b0);
        tick();
        mem_arready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0413;
        settle();
        chk("t1_state_data", dbg_state,  S_DATA);
        chk("t1_ifu_rvalid", ifu_rvalid, 1'b1);
        chk("t1_ifu_rdata",  ifu_rdata,  32'h0000_0413);
        chk("t1_mem_rready", mem_rready, 1'b1);
        chk("t1_lsu_rvalid", lsu_rvalid, 1'b0);
        tick();
        mem_rvalid = 1'b0;
        settle();
        chk("t1_idle", dbg_state, S_IDLE);
        chk("t1_ifu_rvalid_end", ifu_rvalid, 1'b0);

        // ---------- test 2: simultaneous, LSU wins ----------
        hs_start = hs_cnt;
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0004;
        lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_1000; lsu_rready = 1'b1;
        settle();
        chk("t2_lsu_arready", lsu_arready, 1'b1);
        chk("t2_ifu_arready", ifu_arready, 1'b0);
        tick();
        lsu_arvalid = 1'b0; mem_arready = 1'b1;
        settle();
        chk("t2_araddr_lsu", mem_araddr, 32'h8000_1000);
        chk("t2_ifu_arready_addr", ifu_arready, 1'b0);
        tick();
        mem_arready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        settle();
        chk("t2_lsu_rvalid", lsu_rvalid, 1'b1);
        chk("t2_lsu_rdata",  lsu_rdata,  32'h1111_2222);
        chk("t2_ifu_rvalid", ifu_rvalid, 1'b0);
        chk("t2_ifu_rdata",  ifu_rdata,  32'h0);
        tick();
        mem_rvalid = 1'b0;
        settle();
        chk("t2_ifu_arready_2nd", ifu_arready, 1'b1);
        tick();
        ifu_arvalid = 1'b0; mem_arready = 1'b1;
        settle();
        chk("t2_araddr_ifu", mem_araddr, 32'h8000_0004);
        tick();
        mem_arready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h3333_4444;
        settle();
        chk("t2_ifu_rdata2", ifu_rdata, 32'h3333_4444);
        chk("t2_lsu_rvalid2", lsu_rvalid, 1'b0);
        tick();
        mem_rvalid = 1'b0;
        settle();
        chk("t2_handshakes", hs_cnt - hs_start, 2);
        chk("t2_idle", dbg_state, S_IDLE);

        // ---------- test 3: mem_arready stalls in ADDR ----------
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0100;
        tick();
        ifu_arvalid = 1'b0;
        lsu_arvalid = 1'b1; lsu_araddr = 32'h9000_0000;
        held_addr = 32'h8000_0100;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("t3_arvalid_wait", mem_arvalid, 1'b1);
            chk("t3_araddr_hold",  mem_araddr,  held_addr);
            chk("t3_no_lsu_arready", lsu_arready, 1'b0);
            tick();
        end
        mem_arready = 1'b1;
        settle();
        chk("t3_arvalid_5th", mem_arvalid, 1'b1);
        chk("t3_araddr_5th",  mem_araddr,  held_addr);
        tick();
        lsu_arvalid = 1'b0; mem_arready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555_6666;
        settle();
        chk("t3_arvalid_data", mem_arvalid, 1'b0);
        chk("t3_ifu_rdata", ifu_rdata, 32'h5555_6666);
        chk("t3_no_lsu_arready_data", lsu_arready, 1'b0);
        tick();
        mem_rvalid = 1'b0;
        settle();
        chk("t3_idle", dbg_state, S_IDLE);

        // ---------- test 4: LSU read backpressure ----------
        lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_2000; lsu_rready = 1'b0;
        tick();
        lsu_arvalid = 1'b0; mem_arready = 1'b1;
        tick();
        mem_arready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t4_state_hold", dbg_state,  S_DATA);
            chk("t4_mem_rready", mem_rready, 1'b0);
            chk("t4_lsu_rvalid", lsu_rvalid, 1'b1);
            chk("t4_lsu_rdata",  lsu_rdata,  32'hDEAD_BEEF);
            tick();
        end
        lsu_rready = 1'b1;
        settle();
        chk("t4_mem_rready_on", mem_rready, 1'b1);
        tick();
        mem_rvalid = 1'b0;
        settle();
        chk("t4_idle", dbg_state, S_IDLE);
        chk("t4_lsu_rvalid_end", lsu_rvalid, 1'b0);

        // ---------- test 5: reset during DATA ----------
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0200; ifu_rready = 1'b1;
        tick();
        mem_arready = 1'b1;
        tick();
        mem_arready = 1'b0; mem_rvalid = 1'b0;
        settle();
        chk("t5_in_data", dbg_state, S_DATA);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("t5_rst_state",   dbg_state,   S_IDLE);
        chk("t5_rst_arvalid", mem_arvalid, 1'b0);
        chk("t5_rst_araddr",  mem_araddr,  32'h0);
        chk("t5_rst_rready",  mem_rready,  1'b0);
        chk("t5_rst_ifu_rv",  ifu_rvalid,  1'b0);
        chk("t5_regrant",     ifu_arready, 1'b1);
        tick();
        ifu_arvalid = 1'b0; mem_arready = 1'b1;
        settle();
        chk("t5_araddr", mem_araddr, 32'h8000_0200);
        tick();
        mem_arready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h7777_8888;
        settle();
        chk("t5_ifu_rdata", ifu_rdata, 32'h7777_8888);
        tick();
        mem_rvalid = 1'b0;

        // ---------- test 6: error response passthrough ----------
        lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_3000; lsu_rready = 1'b1;
        tick();
        lsu_arvalid = 1'b0; mem_arready = 1'b1;
        tick();
        mem_arready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001; mem_rresp = 2'b10;
        settle();
        chk("t6_lsu_rresp", lsu_rresp, 2'b10);
        chk("t6_ifu_rresp", ifu_rresp, 2'b00);
        chk("t6_lsu_rdata", lsu_rdata, 32'hCAFE_0001);
        tick();
        mem_rvalid = 1'b0; mem_rresp = 2'b00;
        settle();
        chk("t6_idle", dbg_state, S_IDLE);
        chk("t6_lsu_rresp_idle", lsu_rresp, 2'b00);

        // ---------- report ----------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
